// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: multi-line, maskable, prioritised, vectored CP0 interrupt controller
// with MFC0/MTC0/ERET access. Define CP0_TIMER_EN to add the COUNT/COMPARE timer interrupt.
module cp0_irq_ctrl #(
  parameter int unsigned IRQ_NUM    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic               ret_valid,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr
);

  localparam logic [1:0]  OP_MTC0    = 2'b10;
  localparam logic [1:0]  OP_ERET    = 2'b11;
  localparam logic [4:0]  REG_STATUS = 5'd12;
  localparam logic [4:0]  REG_CAUSE  = 5'd13;
  localparam logic [4:0]  REG_EPC    = 5'd14;
  localparam int unsigned IM_LO      = 8;
`ifdef CP0_TIMER_EN
  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam int unsigned NPEND       = IRQ_NUM + 1;
`else
  localparam int unsigned NPEND       = IRQ_NUM;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_HANDLER = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IRQ_NUM-1:0] sync1_q;
  logic [IRQ_NUM-1:0] sync2_q;
  logic [IRQ_NUM-1:0] sync3_q;
  logic [IRQ_NUM-1:0] ip_q;
  logic [IRQ_NUM-1:0] im_q;
  logic [IRQ_NUM-1:0] irq_edge;
  logic [IRQ_NUM-1:0] ip_clr;
  logic               ie_q;
  logic               exl_q;
  logic [4:0]         exc_q;
  logic [31:0]        epc_q;
  logic [NPEND-1:0]   pend;
  logic [4:0]         take_idx;
  logic [31:0]        vec_addr;
  logic               is_mtc0;
  logic               is_eret;
  logic               wr_status;
  logic               wr_cause;
  logic               wr_epc;
  logic               take_c;
  logic               eret_c;
  logic               jump_en_d;
  logic [31:0]        jump_addr_d;
  logic [31:0]        status_rd;
  logic [31:0]        cause_rd;
  logic               unused_data_w;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_d;
  logic        ti_q;
  logic        imti_q;
  logic        wr_count;
  logic        wr_compare;
`endif

  assign unused_data_w = ^data_w;

  // Decode of the register-access operation
  assign is_mtc0   = (oper == OP_MTC0);
  assign is_eret   = (oper == OP_ERET);
  assign wr_status = is_mtc0 && (addr_w == REG_STATUS);
  assign wr_cause  = is_mtc0 && (addr_w == REG_CAUSE);
  assign wr_epc    = is_mtc0 && (addr_w == REG_EPC);
  assign ip_clr    = wr_cause ? data_w[IM_LO +: IRQ_NUM] : '0;
  assign irq_edge  = sync2_q & ~sync3_q;

`ifdef CP0_TIMER_EN
  assign wr_count   = is_mtc0 && (addr_w == REG_COUNT);
  assign wr_compare = is_mtc0 && (addr_w == REG_COMPARE);
  assign count_d    = wr_count ? data_w : count_q + 32'd1;
  assign pend       = {ti_q & imti_q, ip_q & im_q};
`else
  assign pend       = ip_q & im_q;
`endif

  // Lowest set index wins
  always_comb begin
    take_idx = '0;
    for (int i = int'(NPEND) - 1; i >= 0; i--) begin
      if (pend[i]) take_idx = 5'(i);
    end
  end

  assign vec_addr = VEC_BASE + VEC_STRIDE * 32'(take_idx);

  // ERET outranks an interrupt; TAKE/RETURN ignore ERET to keep jump_en single-cycle
  assign eret_c = is_eret && ((state_q == S_IDLE) || (state_q == S_HANDLER));
  assign take_c = (state_q == S_IDLE) && ie_q && !exl_q && (|pend) && ret_valid && !is_eret;

  // State and redirect registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end else begin
      state_q   <= state_d;
      jump_en   <= jump_en_d;
      jump_addr <= jump_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (eret_c)      state_d = S_RETURN;
        else if (take_c) state_d = S_TAKE;
      end
      S_TAKE:    state_d = S_HANDLER;
      S_HANDLER: if (eret_c) state_d = S_RETURN;
      S_RETURN:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Redirect outputs
  always_comb begin
    jump_en_d   = 1'b0;
    jump_addr_d = jump_addr;
    if (eret_c) begin
      jump_en_d   = 1'b1;
      jump_addr_d = epc_q;
    end else if (take_c) begin
      jump_en_d   = 1'b1;
      jump_addr_d = vec_addr;
    end
  end

  // CP0 register file, synchronisers and pending bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      ip_q    <= '0;
      im_q    <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      exc_q   <= '0;
      epc_q   <= '0;
`ifdef CP0_TIMER_EN
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      imti_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      ip_q    <= (ip_q & ~ip_clr) | irq_edge;
      if (wr_status) begin
        ie_q  <= data_w[0];
        exl_q <= data_w[1];
        im_q  <= data_w[IM_LO +: IRQ_NUM];
      end
      if (wr_epc) epc_q <= data_w;
      if (take_c) begin
        exl_q <= 1'b1;
        epc_q <= ret_addr;
        exc_q <= take_idx;
      end else if (eret_c && (state_q == S_HANDLER)) begin
        exl_q <= 1'b0;
      end
`ifdef CP0_TIMER_EN
      count_q <= count_d;
      if (wr_status) imti_q <= data_w[30];
      if (wr_compare) begin
        compare_q <= data_w;
        ti_q      <= 1'b0;
      end else if (count_d == compare_q) begin
        ti_q <= 1'b1;
      end
`endif
    end
  end

  // MFC0 read mux
  always_comb begin
    status_rd                   = '0;
    status_rd[0]                = ie_q;
    status_rd[1]                = exl_q;
    status_rd[IM_LO +: IRQ_NUM] = im_q;
    cause_rd                    = '0;
    cause_rd[6:2]               = exc_q;
    cause_rd[IM_LO +: IRQ_NUM]  = ip_q;
`ifdef CP0_TIMER_EN
    status_rd[30]               = imti_q;
    cause_rd[30]                = ti_q;
`endif
    data_r = '0;
    case (addr_r)
      REG_STATUS:  data_r = status_rd;
      REG_CAUSE:   data_r = cause_rd;
      REG_EPC:     data_r = epc_q;
`ifdef CP0_TIMER_EN
      REG_COUNT:   data_r = count_q;
      REG_COMPARE: data_r = compare_q;
`endif
      default:     data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: expected redirects are queued with their
// target address and cycle, and the monitor pops them whenever jump_en fires.
module tb_cp0_irq_ctrl;
  localparam int unsigned IRQ_NUM = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         oper;
  logic [4:0]         addr_r;
  logic [31:0]        data_r;
  logic [4:0]         addr_w;
  logic [31:0]        data_w;
  logic [IRQ_NUM-1:0] ir_in;
  logic               ret_valid;
  logic [31:0]        ret_addr;
  logic               jump_en;
  logic [31:0]        jump_addr;

  typedef struct {
    logic [31:0] addr;
    int          at;
  } jump_t;

  jump_t exp_q[$];
  jump_t mon_e;
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;
  logic  prev_je = 1'b0;

  cp0_irq_ctrl #(.IRQ_NUM(IRQ_NUM)) dut (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_in(ir_in), .ret_valid(ret_valid),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Redirect monitor: each pulse must be isolated and match the queue head
  always @(negedge clk) begin
    if (jump_en === 1'b1) begin
      checks++;
      if (prev_je === 1'b1) $display("FAIL jump_adjacent cyc=%0d got two consecutive pulses, required a gap", cyc);
      else passes++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL jump_unexpected cyc=%0d got addr=%h required no jump", cyc, jump_addr);
      end else begin
        passes++;
        mon_e = exp_q.pop_front();
        checks++;
        if (jump_addr !== mon_e.addr) $display("FAIL jump_addr cyc=%0d got=%h required=%h", cyc, jump_addr, mon_e.addr);
        else passes++;
        checks++;
        if (cyc != mon_e.at) $display("FAIL jump_cycle addr=%h got cyc=%0d required cyc=%0d", mon_e.addr, cyc, mon_e.at);
        else passes++;
      end
    end
    prev_je = jump_en;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_jump(input logic [31:0] a, input int at);
    jump_t e;
    e.addr = a;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr_r = a;
    #1;
    d = data_r;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    oper = 2'b10; addr_w = a; data_w = d;
    @(negedge clk);
    oper = 2'b00; addr_w = '0; data_w = '0;
  endtask

  task automatic eret();
    oper = 2'b11;
    @(negedge clk);
    oper = 2'b00;
  endtask

  task automatic pulse(input logic [IRQ_NUM-1:0] m);
    ir_in = m;
    @(negedge clk);
    ir_in = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    step(2);
    for (int a = 12; a <= 14; a++) begin
      rd(5'(a), d);
      checks++;
      if (d !== 32'h0) $display("FAIL reset_reg%0d got=%h required=%h", a, d, 32'h0);
      else passes++;
    end
    checks++;
    if (jump_en !== 1'b0 || jump_addr !== 32'h0)
      $display("FAIL reset_jump got en=%b addr=%h required en=0 addr=0", jump_en, jump_addr);
    else passes++;
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_basic_vector();
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_0F01);
    ret_addr = 32'h40;
    expect_jump(32'h120, cyc + 4);
    pulse(4'b0100);
    step(4);
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0F03) $display("FAIL basic_status got=%h required=%h", d, 32'h0000_0F03); else passes++;
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0408) $display("FAIL basic_cause got=%h required=%h", d, 32'h0000_0408); else passes++;
    rd(5'd14, d); checks++;
    if (d !== 32'h0000_0040) $display("FAIL basic_epc got=%h required=%h", d, 32'h0000_0040); else passes++;
    mtc0(5'd13, 32'h0000_0400);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0008) $display("FAIL basic_w1c got=%h required=%h", d, 32'h0000_0008); else passes++;
    expect_jump(32'h40, cyc + 1);
    eret();
    step(2);
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0F01) $display("FAIL basic_eret_status got=%h required=%h", d, 32'h0000_0F01); else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL basic_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask

  task automatic test_priority();
    logic [31:0] d;
    ret_addr = 32'h80;
    expect_jump(32'h110, cyc + 4);
    pulse(4'b1010);
    step(4);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0A04) $display("FAIL prio_cause got=%h required=%h", d, 32'h0000_0A04); else passes++;
    mtc0(5'd13, 32'h0000_0200);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0804) $display("FAIL prio_w1c got=%h required=%h", d, 32'h0000_0804); else passes++;
    ret_addr = 32'h84;
    expect_jump(32'h80, cyc + 1);
    expect_jump(32'h130, cyc + 3);
    eret();
    step(4);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_080C) $display("FAIL prio_cause3 got=%h required=%h", d, 32'h0000_080C); else passes++;
    rd(5'd14, d); checks++;
    if (d !== 32'h0000_0084) $display("FAIL prio_epc3 got=%h required=%h", d, 32'h0000_0084); else passes++;
    mtc0(5'd13, 32'h0000_0800);
    expect_jump(32'h84, cyc + 1);
    eret();
    step(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL prio_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    ret_addr = 32'h200;
    expect_jump(32'h120, cyc + 4);
    pulse(4'b0100);
    step(4);
    mtc0(5'd13, 32'h0000_0400);
    pulse(4'b0001);
    step(3);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0108) $display("FAIL b2b_cause got=%h required=%h", d, 32'h0000_0108); else passes++;
    ret_addr = 32'h204;
    expect_jump(32'h200, cyc + 1);
    expect_jump(32'h100, cyc + 3);
    eret();
    step(4);
    rd(5'd14, d); checks++;
    if (d !== 32'h0000_0204) $display("FAIL b2b_epc got=%h required=%h", d, 32'h0000_0204); else passes++;
    mtc0(5'd13, 32'h0000_0100);
    expect_jump(32'h204, cyc + 1);
    eret();
    step(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask

  task automatic test_mask();
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_0D01);
    pulse(4'b0010);
    step(8);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0200) $display("FAIL mask_ip got=%h required=%h", d, 32'h0000_0200); else passes++;
    ret_addr = 32'h300;
    expect_jump(32'h110, cyc + 2);
    mtc0(5'd12, 32'h0000_0F01);
    step(2);
    // New edge on line 1 lands on the same edge as its W1C
    pulse(4'b0010);
    step(1);
    mtc0(5'd13, 32'h0000_0200);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0204) $display("FAIL mask_set_wins got=%h required=%h", d, 32'h0000_0204); else passes++;
    mtc0(5'd13, 32'h0000_0200);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0004) $display("FAIL mask_w1c got=%h required=%h", d, 32'h0000_0004); else passes++;
    expect_jump(32'h300, cyc + 1);
    eret();
    step(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL mask_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask

  task automatic test_ret_valid();
    logic [31:0] d;
    ret_valid = 1'b0;
    ret_addr  = 32'h600;
    pulse(4'b0100);
    step(6);
    expect_jump(32'h120, cyc + 1);
    ret_valid = 1'b1;
    step(2);
    rd(5'd14, d); checks++;
    if (d !== 32'h0000_0600) $display("FAIL rv_epc got=%h required=%h", d, 32'h0000_0600); else passes++;
    mtc0(5'd13, 32'h0000_0400);
    expect_jump(32'h600, cyc + 1);
    eret();
    step(2);
    // Software ERET from IDLE
    expect_jump(32'h600, cyc + 1);
    eret();
    step(2);
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0F01) $display("FAIL idle_eret_status got=%h required=%h", d, 32'h0000_0F01); else passes++;
    // ERET in the very cycle line 3 first qualifies
    ret_addr = 32'h700;
    pulse(4'b1000);
    step(2);
    expect_jump(32'h600, cyc + 1);
    expect_jump(32'h130, cyc + 3);
    eret();
    step(4);
    rd(5'd14, d); checks++;
    if (d !== 32'h0000_0700) $display("FAIL simul_epc got=%h required=%h", d, 32'h0000_0700); else passes++;
    mtc0(5'd13, 32'h0000_0800);
    expect_jump(32'h700, cyc + 1);
    eret();
    step(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL rv_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    ret_addr = 32'h500;
    expect_jump(32'h120, cyc + 4);
    pulse(4'b0100);
    step(4);
    pulse(4'b1000);
    step(3);
    rst = 1'b0;
    step(1);
    for (int a = 12; a <= 14; a++) begin
      rd(5'(a), d);
      checks++;
      if (d !== 32'h0) $display("FAIL midrst_reg%0d got=%h required=%h", a, d, 32'h0);
      else passes++;
    end
    checks++;
    if (jump_en !== 1'b0 || jump_addr !== 32'h0)
      $display("FAIL midrst_jump got en=%b addr=%h required en=0 addr=0", jump_en, jump_addr);
    else passes++;
    rst = 1'b1;
    step(1);
    mtc0(5'd12, 32'h0000_0F01);
    ret_addr = 32'h510;
    expect_jump(32'h100, cyc + 4);
    pulse(4'b0001);
    step(4);
    rd(5'd14, d); checks++;
    if (d !== 32'h0000_0510) $display("FAIL midrst_epc got=%h required=%h", d, 32'h0000_0510); else passes++;
    mtc0(5'd13, 32'h0000_0100);
    expect_jump(32'h510, cyc + 1);
    eret();
    step(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL midrst_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    logic [31:0] d;
    int c;
    ret_addr = 32'h800;
    c = cyc;
    expect_jump(32'h140, c + 23);
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h4000_0001);
    step(21);
    rd(5'd13, d); checks++;
    if (d !== 32'h4000_0010) $display("FAIL timer_cause got=%h required=%h", d, 32'h4000_0010); else passes++;
    mtc0(5'd11, 32'd20);
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0010) $display("FAIL timer_clear got=%h required=%h", d, 32'h0000_0010); else passes++;
    expect_jump(32'h800, cyc + 1);
    eret();
    step(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL timer_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
  endtask
`else
  task automatic test_no_timer();
    logic [31:0] d;
    mtc0(5'd9, 32'h0000_1234);
    mtc0(5'd11, 32'h0000_0020);
    mtc0(5'd12, 32'h4000_0F01);
    rd(5'd9, d); checks++;
    if (d !== 32'h0) $display("FAIL notimer_count got=%h required=%h", d, 32'h0); else passes++;
    rd(5'd11, d); checks++;
    if (d !== 32'h0) $display("FAIL notimer_compare got=%h required=%h", d, 32'h0); else passes++;
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0F01) $display("FAIL notimer_status got=%h required=%h", d, 32'h0000_0F01); else passes++;
  endtask
`endif

  initial begin
    rst = 1'b0; oper = 2'b00; addr_r = '0; addr_w = '0; data_w = '0;
    ir_in = '0; ret_valid = 1'b1; ret_addr = '0;
    test_reset();
    test_basic_vector();
    test_priority();
    test_back_to_back();
    test_mask();
    test_ret_valid();
    test_reset_mid();
`ifdef CP0_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    step(5);
    checks++;
    if (exp_q.size() != 0) $display("FAIL final_pending got=%0d required=0 outstanding jumps", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Parametrised successor to the single-line CP0: a multi-line, maskable, prioritised, vectored interrupt controller with MFC0/MTC0/ERET register access.
- Sits beside the 5-stage MIPS core, driven by the controller's cp_oper and the datapath's CP0 read/write buses.
- Returns a redirect pulse (jump_en/jump_addr) that the datapath uses to flush and refetch.

Parameters:
- IRQ_NUM, 4, number of external interrupt lines (1..8); line 0 has the highest priority.
- VEC_BASE, 32'h0000_0100, handler address of line 0.
- VEC_STRIDE, 32'h0000_0010, address step between consecutive line vectors.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- oper  in  2  00 none, 01 MFC0, 10 MTC0, 11 ERET.
- addr_r  in  5  CP0 read register number.
- data_r  out  32  CP0 read data, combinational from addr_r.
- addr_w  in  5  CP0 write register number.
- data_w  in  32  CP0 write data.
- ir_in  in  IRQ_NUM  asynchronous interrupt request lines, active-high, edge-triggered.
- ret_valid  in  1  the pipeline can accept a redirect this cycle.
- ret_addr  in  32  restart PC to save in EPC.
- jump_en  out  1  one-cycle redirect pulse.
- jump_addr  out  32  redirect target, valid while jump_en=1.

Behaviour:
- Registers:
  - 12 STATUS: bit0 IE, bit1 EXL, bits[8+IRQ_NUM-1:8] IM.
  - 13 CAUSE: bits[8+IRQ_NUM-1:8] IP, read-only except W1C; bits[6:2] index of the last taken line.
  - 14 EPC.
  - All other addresses read 0 and ignore writes; unimplemented bits read 0.
- Reset (rst=0 at an edge): STATUS, CAUSE, EPC, synchronisers, FSM → 0/IDLE; jump_en=0, jump_addr=0. Reset overrides every other event in the same cycle, including mid-handler.
- Input path: each ir_in line passes through a 2-flop synchroniser plus an edge detector. A rising edge sets IP[i] on the 3rd clk edge after ir_in rises. IP[i] stays set until cleared.
- Clearing IP: MTC0 to CAUSE with data_w bit (8+i)=1 clears IP[i]. If a new edge and the clear land in the same cycle, set wins.
- MTC0 to STATUS or EPC takes effect at the next edge. Interrupt acceptance in that cycle uses the old value.
- FSM:
  - IDLE → TAKE when IE=1, EXL=0, |(IP&IM)=1, ret_valid=1 and oper≠ERET.
  - At that edge:
    - EPC ← ret_addr; EXL ← 1; CAUSE[6:2] ← k, where k is the lowest set index of IP&IM.
    - jump_en ← 1; jump_addr ← VEC_BASE + k*VEC_STRIDE (32-bit wrap).
  - TAKE → HANDLER after one cycle; jump_en returns to 0.
  - HANDLER: further interrupts stay pending (no nesting). On oper=ERET: EXL ← 0, jump_en ← 1, jump_addr ← EPC; go to IDLE through a 1-cycle RETURN state in which no interrupt is taken.
  - ERET while in IDLE: same redirect to EPC (software return), EXL stays 0.
- Simultaneous events:
  - ERET and a qualifying interrupt in the same cycle: ERET wins. The interrupt is taken no earlier than 2 cycles later.
  - ret_valid=0 while an interrupt qualifies: wait in IDLE and keep IP. The interrupt is taken on the first cycle with ret_valid=1.
- Latency: from the qualifying cycle to jump_en is 1 edge. jump_en is never high for 2 consecutive cycles.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Adds reg 9 COUNT (increments every cycle, 32-bit wrap) and reg 11 COMPARE.
  - COUNT==COMPARE sets CAUSE bit30 (TI). TI is masked by STATUS bit30.
  - TI is the lowest priority, with index IRQ_NUM and vector VEC_BASE+IRQ_NUM*VEC_STRIDE.
  - MTC0 to COMPARE clears TI. MTC0 to COUNT loads it.
  - COUNT and COMPARE reset to 0, and TI is suppressed at reset.
- When undefined: regs 9 and 11 read 0, and bit30 reads 0 and cannot be set.

Test Plan:
- Reset with rst=0 for 2 cycles → data_r=0 for addrs 12/13/14, jump_en=0; rst=0 asserted during HANDLER → all state back to 0/IDLE.
- STATUS=32'h0000_0F01, pulse ir_in[2] with ret_valid=1, ret_addr=32'h40 → CAUSE[10]=1 and jump_en=1 with jump_addr=32'h120; EPC=32'h40, STATUS bit1=1, CAUSE[6:2]=2.
- ir_in[3] and ir_in[1] rise together → line 1 taken, jump_addr=32'h110; IP[3] stays set; after ERET plus a W1C of bit 9, line 3 is taken, jump_addr=32'h130.
- In HANDLER: ERET while ir_in[0] pending → jump_addr=EPC first; vector 32'h100 follows ≥2 cycles later, never on adjacent cycles.
- IM[1]=0 with ir_in[1] pulsed → no jump_en; later writing IM[1]=1 → taken on the cycle after the write; W1C concurrent with a new edge keeps IP set.
- CP0_TIMER_EN: COMPARE=20, STATUS=32'h4000_0001 → TI set when COUNT hits 20, jump_addr=VEC_BASE+IRQ_NUM*16=32'h140; MTC0 COMPARE clears TI.
